// File: rtl/ne_wr_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : ne_wr_addr_gen
// Purpose  : Write-side address generator for the layered SISO decoder.
//            Delays the read stream (rd_L, row, layer) by PIPESTAGES cycles
//            through a flushable delay line. The delayed stream drives the
//            L/E write strobes, write address and per-lane E write mask.
//            The module also checks the written row/layer order and reports
//            layer and codeword completion.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            loaden            - new codeword load, acts as reset while high
//            rd_L/rowaddress/LYRindex - read stream from the read FSM
//            wr_L, wr_E, wraddress, wr_lyr, wr_itr - write-side outputs
//            layer_done        - 1-cycle pulse after a layer's last row write
//            decode_done       - level, all 2*MAXITRS layers written
//            seq_err           - sticky sequence-violation flag
// Revision : 1.0 - initial release
// ============================================================================
module ne_wr_addr_gen #(
  parameter int Z           = 511,
  parameter int P           = 26,
  parameter int PIPESTAGES  = 9,
  parameter int MAXITRS     = 10,
  parameter int ROWDEPTH    = 20,
  parameter int P_LAST      = Z - (P * (ROWDEPTH - 1)),
  parameter int ROWWIDTH    = 5,
  parameter int LYRCNTWIDTH = 5,
  parameter int ITRWIDTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                loaden,
  input  logic                rd_L,
  input  logic [ROWWIDTH-1:0] rowaddress,
  input  logic                LYRindex,
  output logic                wr_L,
  output logic [P-1:0]        wr_E,
  output logic [ROWWIDTH-1:0] wraddress,
  output logic                wr_lyr,
  output logic [ITRWIDTH-1:0] wr_itr,
  output logic                layer_done,
  output logic                decode_done,
  output logic                seq_err
);

  localparam logic [ROWWIDTH-1:0]    c_LAST_ROW = ROWWIDTH'(ROWDEPTH - 1);
  localparam logic [LYRCNTWIDTH-1:0] c_LAYERS   = LYRCNTWIDTH'(2 * MAXITRS);
  localparam logic [P-1:0]           c_E_ALL    = {P{1'b1}};
  // The last row of a circulant only carries P_LAST valid lanes.
  localparam logic [P-1:0]           c_E_LAST   = c_E_ALL >> (P - P_LAST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Delay line
  // --------------------------------------------------------------------------
  logic                v_q   [PIPESTAGES];
  logic [ROWWIDTH-1:0] row_q [PIPESTAGES];
  logic                lyr_q [PIPESTAGES];

  logic w_flush;
  assign w_flush = rst | loaden;

  always_ff @(posedge clk) begin
    if (w_flush) begin
      v_q[0]   <= 1'b0;
      row_q[0] <= '0;
      lyr_q[0] <= 1'b0;
    end else begin
      v_q[0]   <= rd_L;
      row_q[0] <= rowaddress;
      lyr_q[0] <= LYRindex;
    end
  end

  generate
    for (genvar s = 1; s < PIPESTAGES; s++) begin : g_stage
      always_ff @(posedge clk) begin
        if (w_flush) begin
          v_q[s]   <= 1'b0;
          row_q[s] <= '0;
          lyr_q[s] <= 1'b0;
        end else begin
          v_q[s]   <= v_q[s-1];
          row_q[s] <= row_q[s-1];
          lyr_q[s] <= lyr_q[s-1];
        end
      end
    end
  endgenerate

  logic                dv;
  logic [ROWWIDTH-1:0] drow;
  logic                dlyr;
  assign dv   = v_q[PIPESTAGES-1];
  assign drow = row_q[PIPESTAGES-1];
  assign dlyr = lyr_q[PIPESTAGES-1];

  // --------------------------------------------------------------------------
  // Sequence FSM and counters
  // --------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [ROWWIDTH-1:0]    exp_row_q, exp_row_d;
  logic [LYRCNTWIDTH-1:0] layer_cnt_q, layer_cnt_d;
  logic                   seq_err_q, seq_err_d;
  logic                   layer_done_q, layer_done_d;

  always_ff @(posedge clk) begin
    if (w_flush) begin
      state_q      <= S_IDLE;
      exp_row_q    <= '0;
      layer_cnt_q  <= '0;
      seq_err_q    <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_row_q    <= exp_row_d;
      layer_cnt_q  <= layer_cnt_d;
      seq_err_q    <= seq_err_d;
      layer_done_q <= layer_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    exp_row_d    = exp_row_q;
    layer_cnt_d  = layer_cnt_q;
    seq_err_d    = seq_err_q;
    layer_done_d = 1'b0;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (dv) begin
          state_d = S_RUN;
          // A mismatching write is still performed and still advances the
          // counters; only the sticky flag records the violation.
          if ((drow != exp_row_q) || (dlyr != layer_cnt_q[0])) begin
            seq_err_d = 1'b1;
          end
          if (exp_row_q == c_LAST_ROW) begin
            exp_row_d    = '0;
            layer_cnt_d  = layer_cnt_q + 1'b1;
            layer_done_d = 1'b1;
            if ((layer_cnt_q + 1'b1) == c_LAYERS) begin
              state_d = S_DONE;
            end
          end else begin
            exp_row_d = exp_row_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // Any write after completion is illegal and is suppressed.
        if (dv) begin
          seq_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign wr_L        = dv && (state_q != S_DONE);
  assign wr_E        = wr_L ? ((drow == c_LAST_ROW) ? c_E_LAST : c_E_ALL) : '0;
  assign wraddress   = drow;
  assign wr_lyr      = dlyr;
  assign wr_itr      = ITRWIDTH'(layer_cnt_q >> 1);
  assign layer_done  = layer_done_q;
  assign decode_done = (state_q == S_DONE);
  assign seq_err     = seq_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ne_wr_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ne_wr_addr_gen
// Purpose  : Self-checking bench for ne_wr_addr_gen. Stimulus pushes the
//            expected write (cycle, row, layer, mask, iteration) into a
//            scoreboard queue; a monitor pops and compares on every wr_L.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ne_wr_addr_gen;

  localparam int PS = 9;

  logic        clk;
  logic        rst;
  logic        loaden;
  logic        rd_L;
  logic [4:0]  rowaddress;
  logic        LYRindex;
  logic        wr_L;
  logic [25:0] wr_E;
  logic [4:0]  wraddress;
  logic        wr_lyr;
  logic [3:0]  wr_itr;
  logic        layer_done;
  logic        decode_done;
  logic        seq_err;

  ne_wr_addr_gen dut (
    .clk         (clk),
    .rst         (rst),
    .loaden      (loaden),
    .rd_L        (rd_L),
    .rowaddress  (rowaddress),
    .LYRindex    (LYRindex),
    .wr_L        (wr_L),
    .wr_E        (wr_E),
    .wraddress   (wraddress),
    .wr_lyr      (wr_lyr),
    .wr_itr      (wr_itr),
    .layer_done  (layer_done),
    .decode_done (decode_done),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] row;
    logic       lyr;
    logic [3:0] itr;
    bit         le;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ld_cyc = -1;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares every presented write against the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if ((cyc == ld_cyc) || (layer_done === 1'b1))
        chk("layer_done", 32'(layer_done), 32'(cyc == ld_cyc));
      if (wr_L !== 1'b0) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write at cycle %0d: got wr_L=%0b row=%0d expected no write",
                   cyc, wr_L, wraddress);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(e.cyc));
          chk("wraddress", 32'(wraddress), 32'(e.row));
          chk("wr_lyr", 32'(wr_lyr), 32'(e.lyr));
          chk("wr_itr", 32'(wr_itr), 32'(e.itr));
          chk("wr_E", 32'(wr_E), (e.row == 5'd19) ? 32'h001FFFF : 32'h3FFFFFF);
          if (e.le) ld_cyc = cyc + 1;
        end
      end
    end
  end

  task automatic drive(input bit rd, input int row, input bit lyr, input int itr, input bit le);
    exp_t e;
    @(negedge clk);
    rd_L       = rd;
    rowaddress = 5'(row);
    LYRindex   = lyr;
    if (rd) begin
      e.cyc = cyc + PS;
      e.row = 5'(row);
      e.lyr = lyr;
      e.itr = 4'(itr);
      e.le  = le;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // Drop expected writes that a flush at this edge discards.
  task automatic flush_sb(input int c);
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].cyc > c) sb.delete(i);
  endtask

  task automatic pulse(input bit use_rst);
    @(negedge clk);
    rd_L = 1'b0;
    if (use_rst) rst = 1'b1; else loaden = 1'b1;
    flush_sb(cyc);
    @(negedge clk);
    rst    = 1'b0;
    loaden = 1'b0;
  endtask

  // Nominal 29-cycle-per-layer schedule over nlayers layers.
  task automatic run_layers(input int nlayers, input bit rst_final);
    for (int l = 0; l < nlayers; l++) begin
      int gap;
      for (int r = 0; r < 20; r++)
        drive(1'b1, r, 1'(l % 2), l / 2, (r == 19) && !(rst_final && l == 19));
      gap = (rst_final && l == 19) ? 8 : 9;
      for (int g = 0; g < gap; g++) begin
        idle(1);
        if (l == 19 && g == 8) chk("decode_done_at_final_write", 32'(decode_done), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; loaden = 1'b0; rd_L = 1'b0; rowaddress = '0; LYRindex = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_L", 32'(wr_L), 32'd0);
    chk("rst_wr_E", 32'(wr_E), 32'd0);
    chk("rst_wraddress", 32'(wraddress), 32'd0);
    chk("rst_wr_lyr", 32'(wr_lyr), 32'd0);
    chk("rst_wr_itr", 32'(wr_itr), 32'd0);
    chk("rst_layer_done", 32'(layer_done), 32'd0);
    chk("rst_decode_done", 32'(decode_done), 32'd0);
    chk("rst_seq_err", 32'(seq_err), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single row 3, layer 0.
    idle(6);
    drive(1'b1, 3, 1'b0, 0, 1'b0);
    idle(12);
    pulse(1'b1);

    // Full 20-layer decode.
    run_layers(20, 1'b0);
    idle(1);
    chk("decode_done_after_final", 32'(decode_done), 32'd1);
    chk("seq_err_clean_decode", 32'(seq_err), 32'd0);
    chk("wr_itr_after_done", 32'(wr_itr), 32'd10);
    // Read after completion: write suppressed, seq_err set.
    drive(1'b1, 0, 1'b0, 0, 1'b0);
    void'(sb.pop_back());
    for (int i = 0; i < 10; i++) begin
      idle(1);
      if (i == 8) begin
        chk("wr_L_after_done", 32'(wr_L), 32'd0);
        chk("seq_err_before_late", 32'(seq_err), 32'd0);
      end
      if (i == 9) chk("seq_err_after_late", 32'(seq_err), 32'd1);
    end
    chk("decode_done_held", 32'(decode_done), 32'd1);
    pulse(1'b1);

    // Skip row 5 in layer 0.
    begin
      int k = 0;
      for (int r = 0; r < 20; r++) begin
        if (r != 5) begin
          drive(1'b1, r, 1'b0, 0, 1'b0);
          if (k == 14) chk("seq_err_at_row6_write", 32'(seq_err), 32'd0);
          if (k == 15) chk("seq_err_after_row6", 32'(seq_err), 32'd1);
          k++;
        end
      end
    end
    idle(12);
    chk("seq_err_sticky", 32'(seq_err), 32'd1);
    pulse(1'b0);
    chk("seq_err_cleared_by_loaden", 32'(seq_err), 32'd0);

    // loaden after 4 reads of layer 7.
    run_layers(7, 1'b0);
    chk("wr_itr_layer7", 32'(wr_itr), 32'd3);
    for (int r = 0; r < 4; r++) drive(1'b1, r, 1'b1, 3, 1'b0);
    pulse(1'b0);
    idle(15);
    chk("flush_wr_itr", 32'(wr_itr), 32'd0);
    chk("flush_seq_err", 32'(seq_err), 32'd0);
    chk("flush_decode_done", 32'(decode_done), 32'd0);
    run_layers(20, 1'b0);
    idle(1);
    chk("fresh_decode_done", 32'(decode_done), 32'd1);
    chk("fresh_seq_err", 32'(seq_err), 32'd0);
    pulse(1'b1);

    // rst coinciding with the final row-19 write.
    run_layers(20, 1'b1);
    pulse(1'b1);
    chk("rstprio_decode_done", 32'(decode_done), 32'd0);
    idle(3);
    chk("rstprio_decode_done_later", 32'(decode_done), 32'd0);
    chk("rstprio_seq_err", 32'(seq_err), 32'd0);
    chk("rstprio_wr_itr", 32'(wr_itr), 32'd0);
    drive(1'b1, 0, 1'b0, 0, 1'b0);
    idle(11);
    chk("rstprio_idle_seq_err", 32'(seq_err), 32'd0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d: got no completion expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
